// File: rtl/sram_like_resp.sv
// SRAM-like responder: single-outstanding request/response memory with a fixed
// handshake-to-response latency and byte-lane writes.
module sram_like_resp #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned AW      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        addr_ok_o,
    output logic        data_ok_o,
    output logic [31:0] rdata_o
);

    localparam logic [3:0] CntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q;
    logic [3:0]      be_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     mem_q [(1 << AW)];

    logic            hs;
    logic [3:0]      be_in;
    logic [AW-1:0]   idx_in;
    logic            commit;
    logic            cm_wr;
    logic [3:0]      cm_be;
    logic [AW-1:0]   cm_idx;
    logic [31:0]     cm_wdata;
    logic            unused_addr;

    // Upper address bits alias onto the same words.
    assign unused_addr = ^addr_i[31:AW+2];
    assign idx_in      = addr_i[AW+1:2];

    assign addr_ok_o = (state_q == StIdle) && !rst;
    assign data_ok_o = (state_q == StResp);
    assign rdata_o   = rdata_q;
    assign hs        = req_i && addr_ok_o;

    always_comb begin
        be_in = 4'b1111;
        case (size_i)
            2'd0:    be_in = 4'b0001 << addr_i[1:0];
            2'd1:    be_in = addr_i[1] ? 4'b1100 : 4'b0011;
            default: be_in = 4'b1111;
        endcase
    end

    // commit marks the edge entering StResp; with LATENCY=1 that is the
    // handshake edge itself, so the live inputs are used instead of latches.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit   = 1'b0;
        cm_wr    = wr_q;
        cm_be    = be_q;
        cm_idx   = idx_q;
        cm_wdata = wdata_q;
        case (state_q)
            StIdle: begin
                if (hs) begin
                    if (LATENCY == 1) begin
                        state_d  = StResp;
                        commit   = 1'b1;
                        cm_wr    = wr_i;
                        cm_be    = be_in;
                        cm_idx   = idx_in;
                        cm_wdata = wdata_i;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (commit) begin
            rdata_d = cm_wr ? 32'd0 : mem_q[cm_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            wr_q    <= 1'b0;
            be_q    <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (hs) begin
                wr_q    <= wr_i;
                be_q    <= be_in;
                idx_q   <= idx_in;
                wdata_q <= wdata_i;
            end
        end
    end

    // Storage is not reset; reset only blocks a pending commit via the FSM.
    always_ff @(posedge clk) begin
        if (commit && cm_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (cm_be[i]) begin
                    mem_q[cm_idx][8*i +: 8] <= cm_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_like_resp.sv
// Directed bench for sram_like_resp: LATENCY=2 vector table plus LATENCY=3
// throughput and LATENCY=1 back-to-back sequences.
module tb_sram_like_resp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req1 = 0, wr1 = 0, aok1, dok1;
    logic [1:0]  size1 = 2;
    logic [31:0] addr1 = 0, wdata1 = 0, rdata1;
    logic        req2 = 0, wr2 = 0, aok2, dok2;
    logic [1:0]  size2 = 2;
    logic [31:0] addr2 = 0, wdata2 = 0, rdata2;
    logic        req3 = 0, wr3 = 0, aok3, dok3;
    logic [1:0]  size3 = 2;
    logic [31:0] addr3 = 0, wdata3 = 0, rdata3;

    sram_like_resp #(.LATENCY(1), .AW(10)) u1 (
        .clk(clk), .rst(rst), .req_i(req1), .wr_i(wr1), .size_i(size1), .addr_i(addr1),
        .wdata_i(wdata1), .addr_ok_o(aok1), .data_ok_o(dok1), .rdata_o(rdata1)
    );
    sram_like_resp #(.LATENCY(2), .AW(10)) u2 (
        .clk(clk), .rst(rst), .req_i(req2), .wr_i(wr2), .size_i(size2), .addr_i(addr2),
        .wdata_i(wdata2), .addr_ok_o(aok2), .data_ok_o(dok2), .rdata_o(rdata2)
    );
    sram_like_resp #(.LATENCY(3), .AW(10)) u3 (
        .clk(clk), .rst(rst), .req_i(req3), .wr_i(wr3), .size_i(size3), .addr_i(addr3),
        .wdata_i(wdata3), .addr_ok_o(aok3), .data_ok_o(dok3), .rdata_o(rdata3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One LATENCY=2 transaction; returns response latency and rdata at data_ok.
    task automatic do_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        int n;
        chk("addr_ok before req", {31'd0, aok2}, 32'd1);
        req2 = 1; wr2 = w; size2 = sz; addr2 = a; wdata2 = wd;
        @(posedge clk);
        @(negedge clk);
        req2 = 0;
        n = 1;
        while (!dok2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        rd  = rdata2;
        @(negedge clk);
        chk("data_ok one-cycle pulse", {31'd0, dok2}, 32'd0);
        chk("rdata holds after resp", rdata2, rd);
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] rd;
        int          lat;
        int          hs_mask, dok_mask, hs_cnt;
        logic        saw_dok;
        logic [31:0] pat [2];

        vecs[0]  = '{"w word 10",      1'b1, 2'd2, 32'h10,   32'hDEADBEEF, 32'h0};
        vecs[1]  = '{"r word 10",      1'b0, 2'd2, 32'h10,   32'h0,        32'hDEADBEEF};
        vecs[2]  = '{"w word 10 b",    1'b1, 2'd2, 32'h10,   32'h11223344, 32'h0};
        vecs[3]  = '{"w byte 11",      1'b1, 2'd0, 32'h11,   32'h0000AA00, 32'h0};
        vecs[4]  = '{"r after byte",   1'b0, 2'd2, 32'h10,   32'h0,        32'h1122AA44};
        vecs[5]  = '{"w half 13",      1'b1, 2'd1, 32'h13,   32'hBEEF0000, 32'h0};
        vecs[6]  = '{"r byte-size 12", 1'b0, 2'd0, 32'h12,   32'h0,        32'hBEEFAA44};
        vecs[7]  = '{"w alias 1000",   1'b1, 2'd2, 32'h1000, 32'h00000055, 32'h0};
        vecs[8]  = '{"r alias 0",      1'b0, 2'd3, 32'h0,    32'h0,        32'h00000055};
        vecs[9]  = '{"w byte 23",      1'b1, 2'd0, 32'h23,   32'h77665544, 32'h0};
        vecs[10] = '{"w half 21",      1'b1, 2'd1, 32'h21,   32'h12345678, 32'h0};
        vecs[11] = '{"r word 20",      1'b0, 2'd2, 32'h20,   32'h0,        32'h77005678};

        // Reset state is asynchronous: checked before any clock edge.
        #1;
        chk("reset addr_ok", {31'd0, aok2}, 32'd0);
        chk("reset data_ok", {31'd0, dok2}, 32'd0);
        chk("reset rdata",   rdata2,        32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("addr_ok first cycle after reset", {31'd0, aok2}, 32'd1);

        // Word 0x20 cleared first so the later byte/half writes have a known base.
        do_txn(1'b1, 2'd2, 32'h20, 32'h0, rd, lat);
        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, lat);
            chk({vecs[i].name, " latency"}, 32'(lat), 32'd2);
            chk({vecs[i].name, " rdata"},   rd,       vecs[i].exp);
        end

        // Reset in WAIT aborts the write: no response, no commit.
        @(negedge clk);
        req2 = 1; wr2 = 1; size2 = 2; addr2 = 32'h10; wdata2 = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req2 = 0;
        rst  = 1;
        #1;
        chk("abort data_ok in reset", {31'd0, dok2}, 32'd0);
        chk("abort addr_ok in reset", {31'd0, aok2}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("addr_ok after abort reset", {31'd0, aok2}, 32'd1);
        saw_dok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            saw_dok |= dok2;
        end
        chk("no data_ok after abort", {31'd0, saw_dok}, 32'd0);
        do_txn(1'b0, 2'd2, 32'h10, 32'h0, rd, lat);
        chk("abort kept old word", rd, 32'hBEEFAA44);

        // LATENCY=3: req held for 12 cycles.
        @(negedge clk);
        req3 = 1; wr3 = 1; size3 = 2; addr3 = 32'h100; wdata3 = 32'h1;
        hs_mask = 0; dok_mask = 0; hs_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (aok3) begin
                hs_mask |= (1 << c);
                hs_cnt++;
            end
            if (dok3) dok_mask |= (1 << c);
            @(negedge clk);
        end
        req3 = 0;
        chk("L3 handshake count", 32'(hs_cnt),   32'd3);
        chk("L3 handshake cycles", 32'(hs_mask), 32'h111);
        chk("L3 data_ok cycles",  32'(dok_mask), 32'h888);

        // LATENCY=1: alternating write/read on one address, req held high.
        pat[0] = 32'hA5A50001;
        pat[1] = 32'h5A5A0002;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("L1 idle addr_ok", {31'd0, aok1}, 32'd1);
            chk("L1 idle data_ok", {31'd0, dok1}, 32'd0);
            req1 = 1; size1 = 2; addr1 = 32'h40;
            wr1 = (k % 2 == 0);
            wdata1 = pat[k / 2];
            @(negedge clk);
            chk("L1 resp data_ok", {31'd0, dok1}, 32'd1);
            chk("L1 resp addr_ok", {31'd0, aok1}, 32'd0);
            chk("L1 resp rdata", rdata1, (k % 2 == 0) ? 32'd0 : pat[k / 2]);
            @(negedge clk);
        end
        req1 = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
